datain_sink: RTL and testbench

//  Receive-side endpoint for the 20-bit flit stream. One instance sits on each local port of the NoC.
//  - Accepts flits qualified by in_valid; there is no backpressure, so the sink always accepts.
//  - Decodes each flit as {payload[15:0], dest_local[3:0]}, where payload = {src_id[7:0], seq[7:0]}.
//  - Checks the destination field and per-source sequence numbers.
//  - Captures flits into a readable memory and raises done when the expected flit count has arrived.

---
 rtl/datain_sink_pkg.sv | 19 +
 rtl/datain_sink_sat_cnt16.sv | 29 ++
 rtl/datain_sink.sv | 138 +++++++++++++
 tb/tb_datain_sink.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/datain_sink_pkg.sv
// Shared NoC flit field layout and receive-FSM state encoding.
// The field constants are also used by the dataout_buf_* generators.
package datain_sink_pkg;

   localparam int unsigned FLIT_W   = 20;
   localparam int unsigned DEST_LSB = 0;
   localparam int unsigned DEST_W   = 4;
   localparam int unsigned SEQ_LSB  = 4;
   localparam int unsigned SEQ_W    = 8;
   localparam int unsigned SRC_LSB  = 12;
   localparam int unsigned SRC_W    = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RECV = 2'd1,
      S_FULL = 2'd2
   } rx_state_e;

endpackage

// File: rtl/datain_sink_sat_cnt16.sv
// 16-bit event counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_cnt16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        en_i,
   output logic [15:0] cnt_o
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != '1))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/datain_sink.sv
// Receive-side NoC endpoint: always accepts flits, checks destination and
// per-source sequence numbers, captures flits into a readable memory.
module datain_sink
   import datain_sink_pkg::*;
#(
   parameter int unsigned DEPTH    = 30,
   parameter int unsigned AW       = 5,
   parameter logic [3:0]  LOCAL_ID = 4'd0,
   parameter int unsigned NUM_SRC  = 4,
   parameter int unsigned EXPECTED = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLIT_W-1:0] datain,
   input  logic              in_valid,
   input  logic              clear,
   input  logic [AW-1:0]     rd_addr,
   output logic [FLIT_W-1:0] rd_data,
   output logic [15:0]       rx_cnt,
   output logic [15:0]       dest_err_cnt,
   output logic [15:0]       seq_err_cnt,
   output logic [15:0]       src_err_cnt,
   output logic [15:0]       drop_cnt,
   output logic              done,
   output logic              full
);

   logic [DEST_W-1:0] dest;
   logic [SEQ_W-1:0]  seq;
   logic [SRC_W-1:0]  src;

   assign dest = datain[DEST_LSB +: DEST_W];
   assign seq  = datain[SEQ_LSB  +: SEQ_W];
   assign src  = datain[SRC_LSB  +: SRC_W];

   rx_state_e         state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic              done_q, done_d;
   logic              mem_we;
   logic [FLIT_W-1:0] mem [DEPTH];
   logic [SEQ_W-1:0]  seq_exp_q [NUM_SRC];
   logic [SEQ_W-1:0]  seq_exp_sel;

   logic        accept, src_bad;
   logic [15:0] rx_next;

   // clear takes priority over a flit arriving in the same cycle
   assign accept  = in_valid && !clear;
   assign src_bad = 32'(src) >= NUM_SRC;
   assign rx_next = rx_cnt + 16'(rx_cnt != '1);

   always_comb begin
      seq_exp_sel = '0;
      for (int unsigned s = 0; s < NUM_SRC; s++)
         if (src == SRC_W'(s))
            seq_exp_sel = seq_exp_q[s];
   end

   sat_cnt16 u_rx   (.clk(clk), .rst_n(rst), .clr_i(clear), .en_i(accept),
                     .cnt_o(rx_cnt));
   sat_cnt16 u_dest (.clk(clk), .rst_n(rst), .clr_i(clear), .en_i(accept && (dest != LOCAL_ID)),
                     .cnt_o(dest_err_cnt));
   sat_cnt16 u_src  (.clk(clk), .rst_n(rst), .clr_i(clear), .en_i(accept && src_bad),
                     .cnt_o(src_err_cnt));
   sat_cnt16 u_seq  (.clk(clk), .rst_n(rst), .clr_i(clear),
                     .en_i(accept && !src_bad && (seq != seq_exp_sel)),
                     .cnt_o(seq_err_cnt));
   sat_cnt16 u_drop (.clk(clk), .rst_n(rst), .clr_i(clear), .en_i(accept && (state_q == S_FULL)),
                     .cnt_o(drop_cnt));

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      done_d   = done_q;
      mem_we   = 1'b0;
      if (clear) begin
         state_d  = S_IDLE;
         wr_ptr_d = '0;
         done_d   = 1'b0;
      end else if (in_valid) begin
         done_d = done_q || (rx_next == 16'(EXPECTED));
         if (state_q != S_FULL) begin
            mem_we = 1'b1;
            // pointer parks on the last slot so it never overflows AW bits
            if (wr_ptr_q == AW'(DEPTH - 1)) begin
               state_d = S_FULL;
            end else begin
               state_d  = S_RECV;
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned s = 0; s < NUM_SRC; s++)
            seq_exp_q[s] <= 8'h01;
      end else if (clear) begin
         for (int unsigned s = 0; s < NUM_SRC; s++)
            seq_exp_q[s] <= 8'h01;
      end else if (accept && !src_bad) begin
         for (int unsigned s = 0; s < NUM_SRC; s++)
            if (src == SRC_W'(s))
               seq_exp_q[s] <= seq + 8'h01;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[wr_ptr_q] <= datain;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rd_data <= '0;
      else if (32'(rd_addr) < DEPTH)
         rd_data <= mem[rd_addr];
      else
         rd_data <= '0;
   end

   assign done = done_q;
   assign full = (state_q == S_FULL);

endmodule

// File: tb/tb_datain_sink.sv
// Directed self-checking bench for datain_sink with hand-computed expectations.
module tb_datain_sink;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] datain;
   logic        in_valid;
   logic        clear;
   logic [4:0]  rd_addr;
   logic [19:0] rd_data;
   logic [15:0] rx_cnt, dest_err_cnt, seq_err_cnt, src_err_cnt, drop_cnt;
   logic        done, full;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   datain_sink #(
      .DEPTH(30), .AW(5), .LOCAL_ID(4'd0), .NUM_SRC(4), .EXPECTED(30)
   ) dut (
      .clk(clk), .rst(rst), .datain(datain), .in_valid(in_valid), .clear(clear),
      .rd_addr(rd_addr), .rd_data(rd_data), .rx_cnt(rx_cnt),
      .dest_err_cnt(dest_err_cnt), .seq_err_cnt(seq_err_cnt),
      .src_err_cnt(src_err_cnt), .drop_cnt(drop_cnt), .done(done), .full(full)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; results are checked one falling edge later.
   task automatic send(input logic [19:0] f);
      datain   = f;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic read(input logic [4:0] a, input logic [19:0] exp, input string tag);
      rd_addr = a;
      @(negedge clk);
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic chk_cnts(input string tag, input int rx, input int de, input int se,
                           input int sr, input int dr, input logic dn, input logic fl);
      chk({tag, ".rx"},   32'(rx_cnt),       rx);
      chk({tag, ".dest"}, 32'(dest_err_cnt), de);
      chk({tag, ".seq"},  32'(seq_err_cnt),  se);
      chk({tag, ".src"},  32'(src_err_cnt),  sr);
      chk({tag, ".drop"}, 32'(drop_cnt),     dr);
      chk({tag, ".done"}, 32'(done),         32'(dn));
      chk({tag, ".full"}, 32'(full),         32'(fl));
   endtask

   function automatic logic [19:0] stream_flit(input int k);
      return 20'h03010 + 20'(k * 16) + 20'(k % 4);
   endfunction

   initial begin
      rst = 1'b0; clear = 1'b0; in_valid = 1'b0; datain = '0; rd_addr = '0;
      repeat (3) @(negedge clk);
      chk_cnts("reset", 0, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("reset.rd_data", 32'(rd_data), 0);
      rst = 1'b1;
      @(negedge clk);

      // 30 flits from src 3, seq 1..30, dest cycling 0..3: 22 have dest != 0
      for (int k = 0; k < 30; k++) begin
         send(stream_flit(k));
         if (k == 28) begin
            chk("pre_done.done", 32'(done), 0);
            chk("pre_done.full", 32'(full), 0);
         end
      end
      chk_cnts("stream30", 30, 22, 0, 0, 0, 1'b1, 1'b1);

      for (int a = 0; a < 30; a++)
         read(5'(a), stream_flit(a), "readback");
      read(5'd30, 20'h00000, "rd_oob30");
      read(5'd31, 20'h00000, "rd_oob31");

      // two extra flits overflow the memory
      send(stream_flit(30));
      send(stream_flit(31));
      chk_cnts("overflow", 32, 24, 0, 0, 2, 1'b1, 1'b1);
      read(5'd29, 20'h031E1, "mem29_kept");

      // clear wins over a simultaneous flit
      clear = 1'b1; datain = 20'h05010; in_valid = 1'b1;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      chk_cnts("clear", 0, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("clear.rd_data_kept", 32'(rd_data), 32'h031E1);

      // src 1: seq 01 02 05 06 -> one error at 05
      send(20'h01010);
      send(20'h01020);
      send(20'h01050);
      chk("seq_jump", 32'(seq_err_cnt), 1);
      send(20'h01060);
      chk("seq_resync", 32'(seq_err_cnt), 1);
      read(5'd0, 20'h01010, "clear_wrptr0");

      // src 2: FF (error vs 01), then 00 and 01 follow across the wrap
      send(20'h02FF0);
      chk("seq_ff", 32'(seq_err_cnt), 2);
      send(20'h02000);
      send(20'h02010);
      chk("seq_wrap", 32'(seq_err_cnt), 2);

      // illegal source: no seq check, still stored
      send(20'hFF010);
      chk("src_bad.src", 32'(src_err_cnt), 1);
      chk("src_bad.seq", 32'(seq_err_cnt), 2);
      // dest error alone, then src+dest errors on one flit
      send(20'h00015);
      send(20'hFE013);
      chk_cnts("multi_err", 10, 2, 2, 2, 0, 1'b0, 1'b0);
      read(5'd7, 20'hFF010, "src_bad_stored");
      read(5'd9, 20'hFE013, "multi_stored");

      // same-address read during a write returns the old contents
      rd_addr = 5'd10;
      send(20'h00020);
      chk("rw_same_old", 32'(rd_data), 32'h030B2);
      @(negedge clk);
      chk("rw_same_new", 32'(rd_data), 32'h00020);
      chk("src0_seq_ok", 32'(seq_err_cnt), 2);
      chk("rx11", 32'(rx_cnt), 11);

      // asynchronous reset mid-stream
      send(20'h03ab0);
      rst = 1'b0;
      #1;
      chk_cnts("async_rst", 0, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("async_rst.rd_data", 32'(rd_data), 0);
      @(negedge clk);
      rst = 1'b1;
      send(20'h03AB0);
      chk("post_rst.rx", 32'(rx_cnt), 1);
      chk("post_rst.seq", 32'(seq_err_cnt), 1);
      read(5'd0, 20'h03AB0, "post_rst_mem0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
